// File: rtl/ysyx_22041207_cache_pkg.sv
// Shared definitions for the load/store cache refill controller and the
// 2-way data cache it talks to.
//   state_t     : controller states
//   DWORD_ALIGN : mask that clears the byte offset inside a 64-bit word
//   OFFSET_W / INDEX_W / TAG_W : address split used by the cache arrays
//   dword_align : helper applying DWORD_ALIGN to a byte address
package ysyx_22041207_cache_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        MREQ   = 3'd2,
        MWAIT  = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [63:0] DWORD_ALIGN = ~64'h7;

    localparam int OFFSET_W = 3;
    localparam int INDEX_W  = 6;
    localparam int TAG_W    = 64 - INDEX_W - OFFSET_W;

    function automatic logic [63:0] dword_align(input logic [63:0] addr);
        return addr & DWORD_ALIGN;
    endfunction

endpackage

// File: rtl/ysyx_22041207_cache_refill.sv
// Load/store controller sitting between the LSU and the 2-way data cache.
// Loads are looked up in the cache; a miss fetches the aligned dword from
// memory and refills the cache through its update port. Stores are
// write-through: memory first, then a masked cache update. One transaction
// is in flight at a time and the LSU gets a single-cycle response pulse.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   lsu_req_*                LSU request (valid/ready, wen, addr, wdata, wmask)
//   lsu_resp_*               LSU response pulse, load data, timeout error
//   cache_raddr/hit/rdata    cache lookup
//   cache_upd*               refill strobe + address/data
//   cache_wupd*              store-update strobe + address/data/mask
//   mem_req_*                memory request (valid held until ready)
//   mem_resp_valid/data      memory read data / write acknowledge
module ysyx_22041207_cache_refill
    import ysyx_22041207_cache_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_req_wen,
    input  logic [63:0] lsu_req_addr,
    input  logic [63:0] lsu_req_wdata,
    input  logic [7:0]  lsu_req_wmask,
    output logic        lsu_resp_valid,
    output logic [63:0] lsu_resp_data,
    output logic        lsu_resp_err,
    output logic [63:0] cache_raddr,
    input  logic        cache_hit,
    input  logic [63:0] cache_rdata,
    output logic        cache_upd,
    output logic [63:0] cache_upd_addr,
    output logic [63:0] cache_upd_data,
    output logic        cache_wupd,
    output logic [63:0] cache_wupd_addr,
    output logic [63:0] cache_wupd_data,
    output logic [7:0]  cache_wupd_mask,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wen,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data
);

    // Last MWAIT count value before giving up; the wait lasts TIMEOUT cycles.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg;
    logic        ready_reg;
    logic        wen_reg;
    logic [63:0] addr_reg;      // stored already dword-aligned
    logic [63:0] wdata_reg;
    logic [7:0]  wmask_reg;
    logic [63:0] data_reg;      // load data for the response and the refill
    logic [7:0]  cnt_reg;
    logic        resp_valid_reg;
    logic        resp_err_reg;
    logic [63:0] resp_data_reg;
    logic        upd_reg;
    logic        wupd_reg;
    logic        mreq_valid_reg;
    logic        mreq_wen_reg;
    logic [63:0] mreq_addr_reg;
    logic [63:0] mreq_wdata_reg;
    logic [7:0]  mreq_wmask_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            ready_reg      <= 1'b0;
            wen_reg        <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wmask_reg      <= '0;
            data_reg       <= '0;
            cnt_reg        <= '0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_data_reg  <= '0;
            upd_reg        <= 1'b0;
            wupd_reg       <= 1'b0;
            mreq_valid_reg <= 1'b0;
            mreq_wen_reg   <= 1'b0;
            mreq_addr_reg  <= '0;
            mreq_wdata_reg <= '0;
            mreq_wmask_reg <= '0;
        end else begin
            // Response and cache strobes are single-cycle pulses.
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_data_reg  <= '0;
            upd_reg        <= 1'b0;
            wupd_reg       <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (lsu_req_valid && ready_reg) begin
                        wen_reg   <= lsu_req_wen;
                        addr_reg  <= dword_align(lsu_req_addr);
                        wdata_reg <= lsu_req_wdata;
                        wmask_reg <= lsu_req_wmask;
                        ready_reg <= 1'b0;
                        state_reg <= LOOKUP;
                    end else begin
                        // Also raises ready on the first edge after reset.
                        ready_reg <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (!wen_reg && cache_hit) begin
                        data_reg       <= cache_rdata;
                        resp_data_reg  <= cache_rdata;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= RESP;
                    end else begin
                        // Stores always go to memory regardless of a hit.
                        mreq_valid_reg <= 1'b1;
                        mreq_wen_reg   <= wen_reg;
                        mreq_addr_reg  <= addr_reg;
                        mreq_wdata_reg <= wen_reg ? wdata_reg : 64'd0;
                        mreq_wmask_reg <= wen_reg ? wmask_reg : 8'd0;
                        state_reg      <= MREQ;
                    end
                end
                MREQ: begin
                    if (mem_req_ready) begin
                        mreq_valid_reg <= 1'b0;
                        cnt_reg        <= '0;
                        state_reg      <= MWAIT;
                    end
                end
                MWAIT: begin
                    if (mem_resp_valid) begin
                        resp_valid_reg <= 1'b1;
                        state_reg      <= RESP;
                        if (wen_reg) begin
                            wupd_reg <= 1'b1;
                        end else begin
                            upd_reg       <= 1'b1;
                            data_reg      <= mem_resp_data;
                            resp_data_reg <= mem_resp_data;
                        end
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= 1'b1;
                        state_reg      <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                RESP: begin
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign lsu_req_ready   = ready_reg;
    assign lsu_resp_valid  = resp_valid_reg;
    assign lsu_resp_data   = resp_data_reg;
    assign lsu_resp_err    = resp_err_reg;
    assign cache_raddr     = addr_reg;
    assign cache_upd       = upd_reg;
    assign cache_upd_addr  = addr_reg;
    assign cache_upd_data  = data_reg;
    assign cache_wupd      = wupd_reg;
    assign cache_wupd_addr = addr_reg;
    assign cache_wupd_data = wdata_reg;
    assign cache_wupd_mask = wmask_reg;
    assign mem_req_valid   = mreq_valid_reg;
    assign mem_req_wen     = mreq_wen_reg;
    assign mem_req_addr    = mreq_addr_reg;
    assign mem_req_wdata   = mreq_wdata_reg;
    assign mem_req_wmask   = mreq_wmask_reg;

endmodule

// File: tb/tb_ysyx_22041207_cache_refill.sv
`timescale 1ns/1ps
module tb_ysyx_22041207_cache_refill;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic        lsu_req_wen = 1'b0;
    logic [63:0] lsu_req_addr = '0;
    logic [63:0] lsu_req_wdata = '0;
    logic [7:0]  lsu_req_wmask = '0;
    logic        lsu_resp_valid;
    logic [63:0] lsu_resp_data;
    logic        lsu_resp_err;
    logic [63:0] cache_raddr;
    logic        cache_hit = 1'b0;
    logic [63:0] cache_rdata = '0;
    logic        cache_upd;
    logic [63:0] cache_upd_addr;
    logic [63:0] cache_upd_data;
    logic        cache_wupd;
    logic [63:0] cache_wupd_addr;
    logic [63:0] cache_wupd_data;
    logic [7:0]  cache_wupd_mask;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_wen;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;

    int checks = 0;
    int errors = 0;
    int mem_accepts = 0;

    always #5 clk = ~clk;

    // Count memory request handshakes.
    always @(posedge clk) begin
        if (!rst && mem_req_valid && mem_req_ready) mem_accepts++;
    end

    ysyx_22041207_cache_refill #(.TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
        .lsu_resp_err(lsu_resp_err),
        .cache_raddr(cache_raddr), .cache_hit(cache_hit), .cache_rdata(cache_rdata),
        .cache_upd(cache_upd), .cache_upd_addr(cache_upd_addr), .cache_upd_data(cache_upd_data),
        .cache_wupd(cache_wupd), .cache_wupd_addr(cache_wupd_addr),
        .cache_wupd_data(cache_wupd_data), .cache_wupd_mask(cache_wupd_mask),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    // Advance one clock; outputs are then observed 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wen, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] wmask);
        lsu_req_valid = 1'b1;
        lsu_req_wen   = wen;
        lsu_req_addr  = addr;
        lsu_req_wdata = wdata;
        lsu_req_wmask = wmask;
        step();
        lsu_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (lsu_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", lsu_req_ready); end
        checks++;
        if ({lsu_resp_valid, cache_upd, cache_wupd, mem_req_valid} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes: got %b expected 0000", {lsu_resp_valid, cache_upd, cache_wupd, mem_req_valid});
        end
        checks++;
        if (mem_req_addr !== 64'd0 || lsu_resp_data !== 64'd0) begin
            errors++; $display("FAIL reset_regs: got addr %h data %h expected 0 0", mem_req_addr, lsu_resp_data);
        end
        rst = 1'b0;
        step();
        checks++;
        if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", lsu_req_ready); end
    endtask

    task automatic test_load_hit(input logic [63:0] addr, input logic [63:0] data, input string name);
        int acc0;
        acc0 = mem_accepts;
        cache_hit   = 1'b1;
        cache_rdata = data;
        issue(1'b0, addr, 64'd0, 8'd0);
        checks++;
        if (lsu_req_ready !== 1'b0 || cache_raddr !== {addr[63:3], 3'b000}) begin
            errors++; $display("FAIL %s_lookup: got ready %b raddr %h expected 0 %h", name, lsu_req_ready, cache_raddr, {addr[63:3], 3'b000});
        end
        step();
        checks++;
        if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== data || lsu_resp_err !== 1'b0) begin
            errors++; $display("FAIL %s_resp: got v %b d %h e %b expected 1 %h 0", name, lsu_resp_valid, lsu_resp_data, lsu_resp_err, data);
        end
        checks++;
        if (cache_upd !== 1'b0 || cache_wupd !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL %s_no_side: got upd %b wupd %b mreq %b expected 0 0 0", name, cache_upd, cache_wupd, mem_req_valid);
        end
        cache_hit = 1'b0;
        step();
        checks++;
        if (lsu_resp_valid !== 1'b0 || lsu_req_ready !== 1'b1 || mem_accepts != acc0) begin
            errors++; $display("FAIL %s_done: got v %b ready %b mreqs %0d expected 0 1 0", name, lsu_resp_valid, lsu_req_ready, mem_accepts - acc0);
        end
        $display("hit load %s addr=%h data=%h", name, addr, lsu_resp_data);
    endtask

    task automatic test_load_miss();
        cache_hit     = 1'b0;
        mem_req_ready = 1'b1;
        issue(1'b0, 64'h8000_0013, 64'd0, 8'd0);
        checks++;
        if (cache_raddr !== 64'h8000_0010) begin errors++; $display("FAIL miss_raddr: got %h expected 80000010", cache_raddr); end
        step();
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0010 || mem_req_wen !== 1'b0) begin
            errors++; $display("FAIL miss_mreq: got v %b a %h w %b expected 1 80000010 0", mem_req_valid, mem_req_addr, mem_req_wen);
        end
        step();
        mem_req_ready = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL miss_mreq_drop: got %b expected 0", mem_req_valid); end
        step();
        step();
        checks++;
        if (lsu_resp_valid !== 1'b0 || cache_upd !== 1'b0) begin
            errors++; $display("FAIL miss_early: got v %b upd %b expected 0 0", lsu_resp_valid, cache_upd);
        end
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h1234;
        step();
        mem_resp_valid = 1'b0;
        checks++;
        if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== 64'h1234 || lsu_resp_err !== 1'b0) begin
            errors++; $display("FAIL miss_resp: got v %b d %h e %b expected 1 1234 0", lsu_resp_valid, lsu_resp_data, lsu_resp_err);
        end
        checks++;
        if (cache_upd !== 1'b1 || cache_upd_addr !== 64'h8000_0010 || cache_upd_data !== 64'h1234 || cache_wupd !== 1'b0) begin
            errors++; $display("FAIL miss_refill: got upd %b a %h d %h wupd %b expected 1 80000010 1234 0", cache_upd, cache_upd_addr, cache_upd_data, cache_wupd);
        end
        step();
        checks++;
        if (cache_upd !== 1'b0 || lsu_resp_valid !== 1'b0) begin
            errors++; $display("FAIL miss_pulse: got upd %b v %b expected 0 0", cache_upd, lsu_resp_valid);
        end
        $display("miss load addr=80000013 data=1234");
    endtask

    task automatic test_store();
        cache_hit     = 1'b1;   // a hit must not short-circuit a store
        cache_rdata   = 64'hAAAA;
        mem_req_ready = 1'b1;
        issue(1'b1, 64'h8000_0008, 64'hFF00, 8'h02);
        step();
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_wen !== 1'b1 || mem_req_wmask !== 8'h02 ||
            mem_req_wdata !== 64'hFF00 || mem_req_addr !== 64'h8000_0008) begin
            errors++; $display("FAIL store_mreq: got v %b w %b m %h d %h a %h expected 1 1 02 ff00 80000008",
                               mem_req_valid, mem_req_wen, mem_req_wmask, mem_req_wdata, mem_req_addr);
        end
        step();
        mem_req_ready  = 1'b0;
        cache_hit      = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h7777;
        step();
        mem_resp_valid = 1'b0;
        checks++;
        if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== 64'd0 || lsu_resp_err !== 1'b0) begin
            errors++; $display("FAIL store_resp: got v %b d %h e %b expected 1 0 0", lsu_resp_valid, lsu_resp_data, lsu_resp_err);
        end
        checks++;
        if (cache_wupd !== 1'b1 || cache_wupd_addr !== 64'h8000_0008 || cache_wupd_data !== 64'hFF00 ||
            cache_wupd_mask !== 8'h02 || cache_upd !== 1'b0) begin
            errors++; $display("FAIL store_wupd: got wupd %b a %h d %h m %h upd %b expected 1 80000008 ff00 02 0",
                               cache_wupd, cache_wupd_addr, cache_wupd_data, cache_wupd_mask, cache_upd);
        end
        step();
        checks++;
        if (cache_wupd !== 1'b0) begin errors++; $display("FAIL store_pulse: got %b expected 0", cache_wupd); end
        $display("store addr=80000008 data=ff00 mask=02");
    endtask

    task automatic test_mem_stall();
        int acc0;
        acc0 = mem_accepts;
        mem_req_ready = 1'b0;
        issue(1'b0, 64'h8000_0100, 64'd0, 8'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0100) begin
                errors++; $display("FAIL stall_hold%0d: got v %b a %h expected 1 80000100", i, mem_req_valid, mem_req_addr);
            end
            if (i < 4) step();
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        checks++;
        if (mem_accepts - acc0 != 1 || mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL stall_one_req: got %0d accepts v %b expected 1 0", mem_accepts - acc0, mem_req_valid);
        end
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h0BAD_F00D;
        step();
        mem_resp_valid = 1'b0;
        checks++;
        if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== 64'h0BAD_F00D) begin
            errors++; $display("FAIL stall_resp: got v %b d %h expected 1 0badf00d", lsu_resp_valid, lsu_resp_data);
        end
        step();
        $display("stalled load addr=80000100 data=%h", 64'h0BAD_F00D);
    endtask

    task automatic test_timeout();
        int n;
        int strobes;
        n = 0;
        strobes = 0;
        mem_req_ready = 1'b1;
        issue(1'b0, 64'h8000_0200, 64'd0, 8'd0);
        mem_resp_valid = 1'b1;          // stale response in LOOKUP/MREQ: ignored
        mem_resp_data  = 64'h5555;
        step();
        mem_resp_valid = 1'b0;
        step();                         // now in MWAIT
        mem_req_ready = 1'b0;
        while (lsu_resp_valid !== 1'b1 && n < 400) begin
            if (cache_upd === 1'b1 || cache_wupd === 1'b1) strobes++;
            step();
            n++;
        end
        checks++;
        if (n != 255) begin errors++; $display("FAIL timeout_cycles: got %0d expected 255", n); end
        checks++;
        if (lsu_resp_err !== 1'b1 || lsu_resp_data !== 64'd0 || cache_upd !== 1'b0 || cache_wupd !== 1'b0 || strobes != 0) begin
            errors++; $display("FAIL timeout_resp: got e %b d %h upd %b wupd %b strobes %0d expected 1 0 0 0 0",
                               lsu_resp_err, lsu_resp_data, cache_upd, cache_wupd, strobes);
        end
        step();
        mem_resp_valid = 1'b1;          // late response after abort
        mem_resp_data  = 64'h6666;
        step();
        mem_resp_valid = 1'b0;
        step();
        checks++;
        if (lsu_resp_valid !== 1'b0 || cache_upd !== 1'b0 || lsu_req_ready !== 1'b1) begin
            errors++; $display("FAIL timeout_late: got v %b upd %b ready %b expected 0 0 1", lsu_resp_valid, cache_upd, lsu_req_ready);
        end
        $display("timeout load addr=80000200 cycles=%0d err=1", n);
    endtask

    task automatic test_reset_mid();
        mem_req_ready = 1'b1;
        issue(1'b0, 64'h8000_0300, 64'd0, 8'd0);
        step();
        step();                         // in MWAIT
        mem_req_ready = 1'b0;
        step();
        rst = 1'b1;
        #2;
        checks++;
        if ({lsu_req_ready, lsu_resp_valid, cache_upd, cache_wupd, mem_req_valid} !== 5'b0 ||
            mem_req_addr !== 64'd0 || cache_raddr !== 64'd0) begin
            errors++; $display("FAIL midrst_outputs: got %b addr %h raddr %h expected 00000 0 0",
                               {lsu_req_ready, lsu_resp_valid, cache_upd, cache_wupd, mem_req_valid}, mem_req_addr, cache_raddr);
        end
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h9999;
        step();
        mem_resp_valid = 1'b0;
        rst = 1'b0;
        step();
        checks++;
        if (lsu_req_ready !== 1'b1 || lsu_resp_valid !== 1'b0 || cache_upd !== 1'b0) begin
            errors++; $display("FAIL midrst_release: got ready %b v %b upd %b expected 1 0 0", lsu_req_ready, lsu_resp_valid, cache_upd);
        end
        $display("reset during MWAIT addr=80000300");
        test_load_hit(64'h8000_0400, 64'hBEEF, "after_rst");
    endtask

    initial begin
        test_reset();
        test_load_hit(64'h8000_0010, 64'hDEAD, "hit");
        test_load_miss();
        test_store();
        test_mem_stall();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
